// File: rtl/combo_digit_bank.sv
// ----------------------------------------------------------------------------
// combo_digit_bank
//   Multi-digit up/down entry counter for the combination lock front end.
//   NUM_DIGITS independent digit counters share one cursor (sel). Raw push
//   buttons are synchronised, rising-edge detected and turned into single
//   presses. Each press steps the active digit, or moves the cursor, by one.
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   up       in   raw button, increment active digit
//   down     in   raw button, decrement active digit
//   left     in   raw button, cursor to sel-1 (wraps)
//   right    in   raw button, cursor to sel+1 (wraps)
//   clear    in   synchronous clear, level, already in clk domain
//   numOut   out  packed digits, digit i at numOut[i*DIGIT_W +: DIGIT_W]
//   sel      out  index of the active digit
//   changed  out  one-cycle pulse after any digit value actually changed
// ----------------------------------------------------------------------------
module combo_digit_bank #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_W     = 4,
  parameter int MAX_VAL     = 9,
  parameter int WRAP        = 1,
  parameter int SYNC_STAGES = 2,
  localparam int SEL_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          up,
  input  logic                          down,
  input  logic                          left,
  input  logic                          right,
  input  logic                          clear,
  output logic [NUM_DIGITS*DIGIT_W-1:0] numOut,
  output logic [SEL_W-1:0]              sel,
  output logic                          changed
);

  localparam logic [DIGIT_W-1:0] MAX_D    = DIGIT_W'(MAX_VAL);
  localparam logic [DIGIT_W-1:0] ZERO_D   = {DIGIT_W{1'b0}};
  localparam logic [SEL_W-1:0]   LAST_SEL = SEL_W'(NUM_DIGITS - 1);

  // Button bit positions inside the 4-bit button vectors
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

  logic [3:0]             btn_raw_s;
  logic [3:0]             sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] prime_q;
  logic [3:0]             hist_q;
  logic [3:0]             press_q;
  logic [3:0]             sync_out_s;
  logic                   chain_valid_s;

  logic [DIGIT_W-1:0]     digit_q [NUM_DIGITS];
  logic [DIGIT_W-1:0]     digit_d [NUM_DIGITS];
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic                   changed_q, changed_d;

  logic                   up_s, down_s, left_s, right_s;
  logic [DIGIT_W-1:0]     cur_s, inc_s, dec_s, new_s;
  logic                   any_nz_s;

  assign btn_raw_s     = {right, left, down, up};
  assign sync_out_s    = sync_q[SYNC_STAGES-1];
  // The chain output only reflects the buttons once reset zeros have been
  // flushed out of every stage. Until then the history stays at its reset
  // value of all-ones, so a button held through reset release looks like
  // "already pressed" instead of a fresh 0->1 edge.
  assign chain_valid_s = prime_q[SYNC_STAGES-1];

  // Synchroniser chain, flush tracker, edge history and registered press strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= 4'b0000;
      end
      prime_q <= {SYNC_STAGES{1'b0}};
      hist_q  <= 4'b1111;
      press_q <= 4'b0000;
    end else begin
      sync_q[0]  <= btn_raw_s;
      prime_q[0] <= 1'b1;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k]  <= sync_q[k-1];
        prime_q[k] <= prime_q[k-1];
      end
      if (chain_valid_s) begin
        hist_q  <= sync_out_s;
        press_q <= sync_out_s & ~hist_q;
      end else begin
        hist_q  <= hist_q;
        press_q <= 4'b0000;
      end
    end
  end

  // Opposing presses in the same cycle cancel each other
  assign up_s    = press_q[BTN_UP]    & ~press_q[BTN_DOWN];
  assign down_s  = press_q[BTN_DOWN]  & ~press_q[BTN_UP];
  assign left_s  = press_q[BTN_LEFT]  & ~press_q[BTN_RIGHT];
  assign right_s = press_q[BTN_RIGHT] & ~press_q[BTN_LEFT];

  assign cur_s = digit_q[sel_q];
  assign inc_s = (cur_s == MAX_D)  ? ((WRAP != 0) ? ZERO_D : MAX_D) : cur_s + DIGIT_W'(1);
  assign dec_s = (cur_s == ZERO_D) ? ((WRAP != 0) ? MAX_D : ZERO_D) : cur_s - DIGIT_W'(1);

  // Detect whether any digit holds a nonzero value (drives changed on clear)
  always_comb begin
    any_nz_s = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      any_nz_s = any_nz_s | (|digit_q[i]);
    end
  end

  // Next-state logic: clear wins; otherwise digit op on the pre-move cursor
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_d[i] = digit_q[i];
    end
    sel_d     = sel_q;
    changed_d = 1'b0;
    new_s     = cur_s;
    if (clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_d[i] = ZERO_D;
      end
      sel_d     = {SEL_W{1'b0}};
      changed_d = any_nz_s;
    end else begin
      if (up_s) begin
        new_s = inc_s;
      end else if (down_s) begin
        new_s = dec_s;
      end else begin
        new_s = cur_s;
      end
      digit_d[sel_q] = new_s;
      changed_d      = (new_s != cur_s);
      // With a single digit LAST_SEL is 0, so both moves land back on 0
      if (right_s) begin
        sel_d = (sel_q == LAST_SEL) ? {SEL_W{1'b0}} : sel_q + SEL_W'(1);
      end else if (left_s) begin
        sel_d = (sel_q == {SEL_W{1'b0}}) ? LAST_SEL : sel_q - SEL_W'(1);
      end else begin
        sel_d = sel_q;
      end
    end
  end

  // Digit, cursor and change-pulse state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_q[i] <= ZERO_D;
      end
      sel_q     <= {SEL_W{1'b0}};
      changed_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_q[i] <= digit_d[i];
      end
      sel_q     <= sel_d;
      changed_q <= changed_d;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_pack
    assign numOut[g*DIGIT_W +: DIGIT_W] = digit_q[g];
  end

  assign sel     = sel_q;
  assign changed = changed_q;

endmodule
